// File: rtl/data_mem_pkg.sv
// Shared types and constants for the parametrised data memory.
package data_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam int unsigned READ_FIRST  = 0;
    localparam int unsigned WRITE_FIRST = 1;

    function automatic int unsigned num_bytes(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/data_mem_parity.sv
// Combinational even-parity generator (write side) and checker (read side), one bit per byte.
module data_mem_parity
    import data_mem_pkg::*;
#(
    parameter int unsigned BYTES = 1
) (
    input  logic [8*BYTES-1:0] wr_data_i,
    output logic [BYTES-1:0]   wr_par_o,
    input  logic [8*BYTES-1:0] rd_data_i,
    input  logic [BYTES-1:0]   rd_par_i,
    output logic               rd_err_o
);

    logic [BYTES-1:0] rd_gen;

    always_comb begin
        wr_par_o = '0;
        rd_gen   = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            wr_par_o[i] = ^wr_data_i[8*i +: 8];
            rd_gen[i]   = ^rd_data_i[8*i +: 8];
        end
    end

    assign rd_err_o = |(rd_gen ^ rd_par_i);

endmodule

// File: rtl/data_memory_param.sv
// Parametrised synchronous data RAM: post-reset clear sweep, byte-masked writes, registered read.
// Optional per-byte parity storage and checking when DATA_MEM_PARITY_EN is defined.
module data_memory_param
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned READ_MODE = READ_FIRST
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   endereco,
    input  logic                controle_escrita,
    input  logic                controle_leitura,
    input  logic [DATA_W/8-1:0] habilita_byte,
    input  logic [DATA_W-1:0]   dado_entrada,
    output logic [DATA_W-1:0]   dado_saida,
    output logic                dado_valido,
`ifdef DATA_MEM_PARITY_EN
    output logic                erro_paridade,
`endif
    output logic                ocupado
);

    localparam int unsigned      BYTES    = num_bytes(DATA_W);
    localparam int unsigned      IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;

    logic              in_range;
    logic [IDX_W-1:0]  addr_idx;
    logic              write_first;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] rd_word;

    logic [BYTES-1:0]  wr_be;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;

    assign in_range    = ({1'b0, endereco} < DEPTH_X);
    assign addr_idx    = endereco[IDX_W-1:0];
    assign write_first = (READ_MODE == WRITE_FIRST) && controle_escrita && in_range;
    assign old_word    = in_range ? mem_q[addr_idx] : '0;

    // Write-first collision: enabled bytes bypass from the write data, others come from the array.
    always_comb begin
        rd_word = old_word;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (write_first && habilita_byte[i]) begin
                rd_word[8*i +: 8] = dado_entrada[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_be   = '0;
        wr_idx  = addr_idx;
        wr_data = dado_entrada;
        valid_d = 1'b0;
        dout_d  = dout_q;
        case (state_q)
            CLEAR: begin
                wr_be   = '1;
                wr_idx  = ptr_q;
                wr_data = '0;
                ptr_d   = ptr_q + 1'b1;
                if (ptr_q == LAST_IDX) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end
            end
            IDLE: begin
                if (controle_escrita && in_range) begin
                    wr_be = habilita_byte;
                end
                if (controle_leitura) begin
                    valid_d = 1'b1;
                    dout_d  = rd_word;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (reset_n && wr_be[i]) begin
                mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

`ifdef DATA_MEM_PARITY_EN
    logic [BYTES-1:0] par_q [DEPTH];
    logic [BYTES-1:0] wr_par;
    logic [BYTES-1:0] old_par;
    logic [BYTES-1:0] rd_par;
    logic             rd_err;
    logic             perr_q, perr_d;

    data_mem_parity #(
        .BYTES (BYTES)
    ) u_parity (
        .wr_data_i (wr_data),
        .wr_par_o  (wr_par),
        .rd_data_i (rd_word),
        .rd_par_i  (rd_par),
        .rd_err_o  (rd_err)
    );

    assign old_par = in_range ? par_q[addr_idx] : '0;

    always_comb begin
        rd_par = old_par;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (write_first && habilita_byte[i]) begin
                rd_par[i] = wr_par[i];
            end
        end
    end

    assign perr_d = valid_d & rd_err;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (reset_n && wr_be[i]) begin
                par_q[wr_idx][i] <= wr_par[i];
            end
        end
    end

    assign erro_paridade = perr_q;
`endif

    assign dado_saida  = dout_q;
    assign dado_valido = valid_q;
    assign ocupado     = (state_q == CLEAR);

endmodule

// File: tb/tb_data_memory_param.sv
// Bench for data_memory_param: two 32-bit instances (read-first full depth, write-first shallow)
// driven in lockstep and checked against an array-based reference model.
`timescale 1ns/1ps
module tb_data_memory_param;

    localparam int DEP0 = 256;
    localparam int DEP1 = 200;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        we    = 1'b0;
    logic        re    = 1'b0;
    logic [7:0]  addr  = '0;
    logic [3:0]  be    = '0;
    logic [31:0] din   = '0;

    logic [31:0] dout0, dout1;
    logic        valid0, valid1, busy0, busy1;
`ifdef DATA_MEM_PARITY_EN
    logic        perr0, perr1;
    logic        exp_perr;
    logic        corrupt [256];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mm [2][256];
    int          dep  [2] = '{DEP0, DEP1};
    int          mode [2] = '{0, 1};
    int          busy_left [2];
    logic [31:0] exp_dout [2];
    logic        exp_valid [2];

    typedef struct {
        logic        we;
        logic        re;
        logic [7:0]  addr;
        logic [3:0]  be;
        logic [31:0] din;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t tbl [20];

    data_memory_param #(
        .DATA_W    (32),
        .ADDR_W    (8),
        .DEPTH     (DEP0),
        .READ_MODE (0)
    ) dut0 (
        .clock            (clk),
        .reset_n          (rst_n),
        .endereco         (addr),
        .controle_escrita (we),
        .controle_leitura (re),
        .habilita_byte    (be),
        .dado_entrada     (din),
        .dado_saida       (dout0),
        .dado_valido      (valid0),
`ifdef DATA_MEM_PARITY_EN
        .erro_paridade    (perr0),
`endif
        .ocupado          (busy0)
    );

    data_memory_param #(
        .DATA_W    (32),
        .ADDR_W    (8),
        .DEPTH     (DEP1),
        .READ_MODE (1)
    ) dut1 (
        .clock            (clk),
        .reset_n          (rst_n),
        .endereco         (addr),
        .controle_escrita (we),
        .controle_leitura (re),
        .habilita_byte    (be),
        .dado_entrada     (din),
        .dado_saida       (dout1),
        .dado_valido      (valid1),
`ifdef DATA_MEM_PARITY_EN
        .erro_paridade    (perr1),
`endif
        .ocupado          (busy1)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare just after it.
    task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] a,
                        input logic [3:0] b, input logic [31:0] d);
        logic [31:0] oldw, neww;
        logic        inr;
        logic        idle0;
        rst_n = r; we = w; re = rd; addr = a; be = b; din = d;
        @(posedge clk);
        idle0 = r && (busy_left[0] == 0);
`ifdef DATA_MEM_PARITY_EN
        if (!r) begin
            exp_perr = 1'b0;
            for (int j = 0; j < 256; j++) corrupt[j] = 1'b0;
        end else if (!idle0) begin
            exp_perr = 1'b0;
        end else begin
            exp_perr = rd && corrupt[a];
            if (w && b[0]) corrupt[a] = 1'b0;
        end
`else
        if (idle0) begin end
`endif
        for (int k = 0; k < 2; k++) begin
            if (!r) begin
                busy_left[k] = dep[k];
                exp_dout[k]  = '0;
                exp_valid[k] = 1'b0;
                for (int j = 0; j < 256; j++) mm[k][j] = '0;
            end else if (busy_left[k] > 0) begin
                busy_left[k]--;
                exp_valid[k] = 1'b0;
            end else begin
                inr  = (int'(a) < dep[k]);
                oldw = inr ? mm[k][a] : '0;
                neww = oldw;
                for (int i = 0; i < 4; i++) begin
                    if (b[i]) neww[8*i +: 8] = d[8*i +: 8];
                end
                exp_valid[k] = rd;
                if (rd) exp_dout[k] = !inr ? 32'h0 : ((mode[k] == 1 && w) ? neww : oldw);
                if (w && inr) mm[k][a] = neww;
            end
        end
        #1;
        check("ocupado0", {31'b0, busy0},  {31'b0, busy_left[0] > 0});
        check("ocupado1", {31'b0, busy1},  {31'b0, busy_left[1] > 0});
        check("valido0",  {31'b0, valid0}, {31'b0, exp_valid[0]});
        check("valido1",  {31'b0, valid1}, {31'b0, exp_valid[1]});
        check("saida0",   dout0, exp_dout[0]);
        check("saida1",   dout1, exp_dout[1]);
`ifdef DATA_MEM_PARITY_EN
        check("paridade0", {31'b0, perr0}, {31'b0, exp_perr});
        check("paridade1", {31'b0, perr1}, 32'h0);
`endif
        @(negedge clk);
    endtask

    task automatic rand_step(input logic r);
        logic [7:0] a;
        if (($urandom % 8) == 0) a = 8'($urandom_range(190, 255));
        else                     a = 8'($urandom_range(0, 15));
        step(r, 1'($urandom % 2), 1'($urandom % 2), a, 4'($urandom), $urandom);
    endtask

    // Counts cycles after reset release until each instance drops ocupado.
    task automatic sweep_measure(input int req_until, output int z0, output int z1);
        z0 = 0;
        z1 = 0;
        for (int i = 1; i <= 400 && (z0 == 0 || z1 == 0); i++) begin
            if (i <= req_until) rand_step(1'b1);
            else                step(1'b1, 1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
            if (z0 == 0 && busy0 === 1'b0) z0 = i;
            if (z1 == 0 && busy1 === 1'b0) z1 = i;
        end
    endtask

    initial begin
        int z0, z1;

        tbl[0]  = '{1'b1, 1'b0, 8'h10, 4'hF, 32'h000000A5, 32'h0,        32'h0};
        tbl[1]  = '{1'b0, 1'b1, 8'h10, 4'h0, 32'h0,        32'h000000A5, 32'h000000A5};
        tbl[2]  = '{1'b0, 1'b0, 8'h10, 4'h0, 32'h0,        32'h0,        32'h0};
        tbl[3]  = '{1'b1, 1'b0, 8'h03, 4'hF, 32'h11223344, 32'h0,        32'h0};
        tbl[4]  = '{1'b1, 1'b0, 8'h03, 4'h5, 32'hAABBCCDD, 32'h0,        32'h0};
        tbl[5]  = '{1'b0, 1'b1, 8'h03, 4'h0, 32'h0,        32'h11BB33DD, 32'h11BB33DD};
        tbl[6]  = '{1'b1, 1'b0, 8'h03, 4'h0, 32'hFFFFFFFF, 32'h0,        32'h0};
        tbl[7]  = '{1'b0, 1'b1, 8'h03, 4'h0, 32'h0,        32'h11BB33DD, 32'h11BB33DD};
        tbl[8]  = '{1'b1, 1'b0, 8'h07, 4'hF, 32'h0000000F, 32'h0,        32'h0};
        tbl[9]  = '{1'b1, 1'b1, 8'h07, 4'hF, 32'h000000F0, 32'h0000000F, 32'h000000F0};
        tbl[10] = '{1'b0, 1'b1, 8'h07, 4'h0, 32'h0,        32'h000000F0, 32'h000000F0};
        tbl[11] = '{1'b1, 1'b0, 8'hC8, 4'hF, 32'h5A5A5A5A, 32'h0,        32'h0};
        tbl[12] = '{1'b0, 1'b1, 8'hC8, 4'h0, 32'h0,        32'h5A5A5A5A, 32'h0};
        tbl[13] = '{1'b1, 1'b0, 8'hC7, 4'hF, 32'h00000077, 32'h0,        32'h0};
        tbl[14] = '{1'b0, 1'b1, 8'hC7, 4'h0, 32'h0,        32'h00000077, 32'h00000077};
        tbl[15] = '{1'b0, 1'b1, 8'h42, 4'h0, 32'h0,        32'h0,        32'h0};
        tbl[16] = '{1'b1, 1'b1, 8'hFF, 4'hF, 32'h12345678, 32'h0,        32'h0};
        tbl[17] = '{1'b0, 1'b1, 8'hFF, 4'h0, 32'h0,        32'h12345678, 32'h0};
        tbl[18] = '{1'b0, 1'b1, 8'h10, 4'h0, 32'h0,        32'h000000A5, 32'h000000A5};
        tbl[19] = '{1'b0, 1'b1, 8'h03, 4'h0, 32'h0,        32'h11BB33DD, 32'h11BB33DD};

        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
        sweep_measure(DEP1, z0, z1);
        check("sweep_len0", z0, DEP0);
        check("sweep_len1", z1, DEP1);

        for (int i = 0; i < 20; i++) begin
            step(1'b1, tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].be, tbl[i].din);
            if (tbl[i].re) begin
                check($sformatf("tbl%0d_saida0", i), dout0, tbl[i].exp0);
                check($sformatf("tbl%0d_saida1", i), dout1, tbl[i].exp1);
            end
            check($sformatf("tbl%0d_valido0", i), {31'b0, valid0}, {31'b0, tbl[i].re});
        end

`ifdef DATA_MEM_PARITY_EN
        step(1'b1, 1'b1, 1'b0, 8'h05, 4'hF, 32'h3C3C3C01);
        step(1'b1, 1'b1, 1'b0, 8'h06, 4'hF, 32'h12345678);
        dut0.mem_q[5][0] = ~dut0.mem_q[5][0];
        mm[0][5][0] = ~mm[0][5][0];
        corrupt[5] = 1'b1;
        step(1'b1, 1'b0, 1'b1, 8'h05, 4'h0, 32'h0);
        check("perr_flip",   {31'b0, perr0}, 32'h1);
        check("perr_flip_v", {31'b0, valid0}, 32'h1);
        step(1'b1, 1'b0, 1'b1, 8'h06, 4'h0, 32'h0);
        check("perr_clean",  {31'b0, perr0}, 32'h0);
`endif

        for (int i = 0; i < 300; i++) rand_step(1'b1);

        step(1'b0, 1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
        for (int i = 0; i < 100; i++) rand_step(1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
        sweep_measure(DEP1, z0, z1);
        check("restart_len0", z0, DEP0);
        check("restart_len1", z1, DEP1);

        step(1'b1, 1'b0, 1'b1, 8'h03, 4'h0, 32'h0);
        check("cleared_03", dout0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 8'h07, 4'h0, 32'h0);
        check("cleared_07", dout1, 32'h0);

        for (int i = 0; i < 300; i++) rand_step(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
